// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matmul compute datapath:
//   - FSM state encodings (IDLE, ARM, MAC, OUT, DONE)
//   - clog2 helper usable in parameter expressions
//   - acc_width: accumulator width that cannot overflow for an N-term dot
//     product of DW-bit signed operands
// ---------------------------------------------------------------------------
package matmul_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // 2*DW-bit products plus clog2(N) growth bits for the N-term sum.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/matmul_datapath_mac.sv
// ---------------------------------------------------------------------------
// mac_unit
// Signed multiply-accumulate with clear-on-first.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears the running sum)
//   clr  : this term starts a new dot product (sum = a*b)
//   en   : update the running sum with the current term
//   a, b : signed DW-bit operands
//   acc  : running total INCLUDING the current term (combinational), so the
//          caller can register the final sum in the same cycle as the last
//          term instead of waiting an extra cycle.
// ---------------------------------------------------------------------------
module mac_unit
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 2 * DW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod_p0;
    logic signed [ACC_W-1:0] acc_p1;

    // Stage p0: product and sum of the current term (combinational)
    assign prod_p0 = (2*DW)'(a) * (2*DW)'(b);
    assign acc     = clr ? ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);

    // Stage p1: running sum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1 <= '0;
        end else if (en) begin
            acc_p1 <= acc;
        end
    end

endmodule

// File: rtl/matmul_datapath.sv
// ---------------------------------------------------------------------------
// matmul_datapath
// Compute engine driven by the matmul control FSM. Streams in A then B
// (row-major, signed), computes C = A*B with one MAC per cycle, streams C
// out row-major and pulses done_datapath when the last element is taken.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   load_A_B      while IDLE: rewind the element write pointer
//   start_mul     level; rising edge arms a computation, low aborts it
//   in_valid/in_ready/in_data      element input stream (A then B)
//   out_valid/out_ready/out_data   C output stream, row-major
//   done_datapath one-cycle pulse after the last C handshake
//
// Configuration:
//   MATMUL_DP_SAT_EN  defined   : out_data = accumulator clamped to OUT_W
//                     undefined : out_data = low OUT_W bits (wrap)
// ---------------------------------------------------------------------------
module matmul_datapath
    import matmul_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int OUT_W = 2 * DW,
    parameter int ACC_W = acc_width(DW, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_A_B,
    input  logic                    start_mul,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    done_datapath
);

    localparam int NN   = N * N;
    localparam int FULL = 2 * NN;
    localparam int PW   = clog2(FULL + 1);
    localparam int MW   = clog2(FULL);
    localparam int IW   = clog2(N);

`ifdef MATMUL_DP_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

    // Reduce the accumulator to the output width: clamp or wrap.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (SAT_EN) begin
            if (v > ACC_W'(SAT_HI)) begin
                return SAT_HI;
            end
            if (v < ACC_W'(SAT_LO)) begin
                return SAT_LO;
            end
        end
        return v[OUT_W-1:0];
    endfunction

    logic [2:0]    state;
    logic [PW-1:0] wr_ptr;
    logic [IW-1:0] i_idx;
    logic [IW-1:0] j_idx;
    logic [IW-1:0] k_idx;
    logic          start_q;

    // A occupies entries 0..NN-1, B occupies NN..2*NN-1.
    logic signed [DW-1:0] elem_mem [FULL];

    logic                    rise;
    logic                    full;
    logic                    load_clr;
    logic                    in_fire;
    logic                    abort;
    logic                    last_k;
    logic                    last_elem;
    logic [MW-1:0]           a_idx;
    logic [MW-1:0]           b_idx;
    logic signed [DW-1:0]    mac_a;
    logic signed [DW-1:0]    mac_b;
    logic signed [ACC_W-1:0] mac_acc;

    always_comb begin
        rise      = start_mul & ~start_q;
        full      = (wr_ptr == PW'(FULL));
        load_clr  = (state == ST_IDLE) & load_A_B;
        in_fire   = in_valid & in_ready;
        abort     = ~start_mul & (state != ST_IDLE) & (state != ST_DONE);
        last_k    = (k_idx == IW'(N - 1));
        last_elem = (i_idx == IW'(N - 1)) & (j_idx == IW'(N - 1));
        a_idx     = MW'(int'(i_idx) * N + int'(k_idx));
        b_idx     = MW'(NN + int'(k_idx) * N + int'(j_idx));
        mac_a     = elem_mem[a_idx];
        mac_b     = elem_mem[b_idx];
    end

    // rst gates in_ready so the input stays closed for the whole reset.
    assign in_ready      = ~rst & ((state == ST_IDLE) | (state == ST_ARM)) & ~full;
    assign out_valid     = (state == ST_OUT);
    assign done_datapath = (state == ST_DONE);

    // Element storage: a rewind in IDLE suppresses a coincident write.
    always_ff @(posedge clk) begin
        if (in_fire & ~load_clr) begin
            elem_mem[wr_ptr[MW-1:0]] <= in_data;
        end
    end

    mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (k_idx == '0),
        .en  (state == ST_MAC),
        .a   (mac_a),
        .b   (mac_b),
        .acc (mac_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            start_q  <= 1'b0;
            out_data <= '0;
        end else begin
            start_q <= start_mul;

            if (load_clr) begin
                wr_ptr <= '0;
            end else if (in_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // Abort keeps wr_ptr so a re-rise recomputes the stored matrices.
            if (abort) begin
                state <= ST_IDLE;
                i_idx <= '0;
                j_idx <= '0;
                k_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (full) begin
                            state <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (last_k) begin
                            out_data <= sat_out(mac_acc);
                            k_idx    <= '0;
                            state    <= ST_OUT;
                        end else begin
                            k_idx <= k_idx + 1'b1;
                        end
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            if (last_elem) begin
                                state <= ST_DONE;
                            end else begin
                                if (j_idx == IW'(N - 1)) begin
                                    j_idx <= '0;
                                    i_idx <= i_idx + 1'b1;
                                end else begin
                                    j_idx <= j_idx + 1'b1;
                                end
                                state <= ST_MAC;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_datapath.sv
// ---------------------------------------------------------------------------
// tb_matmul_datapath
// Scoreboard bench for matmul_datapath at N=2, DW=8, OUT_W=16. Stimulus pushes
// the hand-computed C elements into exp_q; the monitor pops and compares on
// every output handshake, checks that stalled output is held, and timestamps
// done pulses for latency checks.
// ---------------------------------------------------------------------------
module tb_matmul_datapath;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load_A_B;
    logic                    start_mul;
    logic                    in_valid;
    logic signed [DW-1:0]    in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_ready;
    logic                    done_datapath;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int t0;
    int dc;
    logic                    prev_done  = 1'b0;
    logic                    stall_prev = 1'b0;
    logic signed [OUT_W-1:0] stall_data = '0;

`ifdef MATMUL_DP_SAT_EN
    localparam int BIG_C = 32767;
`else
    localparam int BIG_C = -32768;
`endif

    matmul_datapath #(
        .N     (N),
        .DW    (DW),
        .OUT_W (OUT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_A_B      (load_A_B),
        .start_mul     (start_mul),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .done_datapath (done_datapath)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare on output handshakes, track stalls and done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0d, expected no element", out_data);
                end else begin
                    check("c_elem", int'(out_data), exp_q.pop_front());
                end
            end
            if (out_valid && stall_prev) begin
                check("stall_hold", int'(out_data), int'(stall_data));
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (done_datapath) begin
                check("done_width", int'(prev_done), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = done_datapath;
        end else begin
            stall_prev = 1'b0;
            prev_done  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input int c0, input int c1, input int c2, input int c3);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
    endtask

    // Stream 8 elements; optionally rewind first; raise start_mul after
    // element number start_after (0 = never).
    task automatic load_elems(input int vals[8], input bit pulse_load, input int start_after);
        int w;
        if (pulse_load) begin
            load_A_B = 1'b1;
            tick();
            load_A_B = 1'b0;
        end
        for (int e = 0; e < 8; e++) begin
            in_valid = 1'b1;
            in_data  = DW'(vals[e]);
            for (w = 0; w < 20 && !in_ready; w++) tick();
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: element %0d not accepted, in_ready=%0d expected 1", e, in_ready);
            end
            tick();
            if (e + 1 == start_after) start_mul = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev_cnt, input string name);
        int w;
        for (w = 0; w < 200 && done_cnt == prev_cnt; w++) tick();
        if (done_cnt == prev_cnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done pulse count %0d, expected %0d within 200 cycles", name, done_cnt, prev_cnt + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        load_A_B  = 1'b0;
        start_mul = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_done", int'(done_datapath), 0);
        check("rst_in_ready", int'(in_ready), 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_in_ready", int'(in_ready), 1);

        // Test 1: basic product and done latency from the start edge.
        load_elems('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1, 0);
        push4(19, 22, 43, 50);
        dc = done_cnt;
        start_mul = 1'b1;
        t0 = cyc;
        wait_done(dc, "t1_done");
        check("t1_latency", done_cyc - t0, 14);
        start_mul = 1'b0;
        repeat (3) tick();
        check("t1_done_count", done_cnt - dc, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // Test 2: start while only 3 elements loaded; MAC follows the 8th.
        push4(19, 22, 43, 50);
        dc = done_cnt;
        load_elems('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1, 3);
        t0 = cyc;
        wait_done(dc, "t2_done");
        check("t2_latency", done_cyc - t0, 13);
        start_mul = 1'b0;
        repeat (2) tick();
        check("t2_queue_empty", exp_q.size(), 0);

        // Test 3: stall element 2 for 5 cycles; recompute stored matrices.
        push4(19, 22, 43, 50);
        dc = done_cnt;
        start_mul = 1'b1;
        t0 = cyc;
        repeat (7) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done(dc, "t3_done");
        check("t3_latency", done_cyc - t0, 19);
        start_mul = 1'b0;
        repeat (2) tick();
        check("t3_queue_empty", exp_q.size(), 0);

        // Test 4: -128 * -128 accumulation exceeds OUT_W.
        load_elems('{-128, -128, -128, -128, -128, -128, -128, -128}, 1'b1, 0);
        push4(BIG_C, BIG_C, BIG_C, BIG_C);
        dc = done_cnt;
        start_mul = 1'b1;
        t0 = cyc;
        wait_done(dc, "t4_done");
        check("t4_latency", done_cyc - t0, 14);
        start_mul = 1'b0;
        repeat (2) tick();
        check("t4_queue_empty", exp_q.size(), 0);

        // Test 5: abort during MAC of element 3, then re-rise.
        load_elems('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1, 0);
        exp_q.push_back(19);
        exp_q.push_back(22);
        dc = done_cnt;
        start_mul = 1'b1;
        repeat (8) tick();
        start_mul = 1'b0;
        tick();
        check("t5_abort_out_valid", int'(out_valid), 0);
        repeat (6) tick();
        check("t5_no_done", done_cnt, dc);
        check("t5_partial_queue", exp_q.size(), 0);
        push4(19, 22, 43, 50);
        start_mul = 1'b1;
        t0 = cyc;
        wait_done(dc, "t5_done");
        check("t5_latency", done_cyc - t0, 14);
        start_mul = 1'b0;
        repeat (2) tick();
        check("t5_queue_empty", exp_q.size(), 0);

        // Test 6: asynchronous reset while holding in OUT.
        out_ready = 1'b0;
        start_mul = 1'b1;
        repeat (6) tick();
        check("t6_in_out", int'(out_valid), 1);
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_out_data", int'(out_data), 0);
        check("t6_rst_done", int'(done_datapath), 0);
        check("t6_rst_in_ready", int'(in_ready), 0);
        tick();
        check("t6_rst_in_ready_held", int'(in_ready), 0);
        #2 rst = 1'b0;
        start_mul = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_release_in_ready", int'(in_ready), 1);
        // No rewind: reset must already have cleared the write pointer.
        load_elems('{2, 0, 0, 2, 1, 2, 3, 4}, 1'b0, 0);
        push4(2, 4, 6, 8);
        dc = done_cnt;
        start_mul = 1'b1;
        t0 = cyc;
        wait_done(dc, "t6_done");
        check("t6_latency", done_cyc - t0, 14);
        start_mul = 1'b0;
        repeat (3) tick();
        check("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
